iter_cipher_stream: RTL and testbench

- Parametrised AXI-Stream front end for an iterative block-cipher round core (e.g. the DES round core).
- Accepts one W-bit block per handshake and sequences the core through ROUNDS round indices.
- Optionally applies CBC chaining in either direction.
- Buffers results in an OUT_DEPTH output FIFO so input acceptance overlaps output back-pressure; sits between the wide UART streams and the round core.

---
 rtl/iter_cipher_stream.sv | 150 +++++++++++++++
 tb/tb_iter_cipher_stream.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_cipher_stream.sv
// iter_cipher_stream
// AXI-Stream front end for an iterative block-cipher round core.
// It accepts one W-bit block per input handshake and steps the core through
// round indices 0..ROUNDS-1. ECB or CBC chaining can be selected per block.
// Results are queued in an OUT_DEPTH first-word-fall-through FIFO.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   s_axis_tdata/tuser/tvalid      input block, mode (1 = decrypt), valid
//   s_axis_tready                  input ready
//   m_axis_tdata/tvalid/tready     result stream
//   cbc_en                         per-block CBC enable, sampled at handshake
//   iv, iv_load                    chain register load (honoured in IDLE only)
//   core_in, core_decrypt          block and mode to core, stable for a run
//   core_round                     round index to core
//   core_out                       core result, final during CAPTURE
//   busy                           high while a block is in the core
//   blk_count                      completed blocks, wraps at 2**32
module iter_cipher_stream #(
   parameter int W         = 64,
   parameter int ROUNDS    = 16,
   parameter int RW        = 4,
   parameter int OUT_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  s_axis_tdata,
   input  logic          s_axis_tuser,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
   output logic [W-1:0]  m_axis_tdata,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   input  logic          cbc_en,
   input  logic [W-1:0]  iv,
   input  logic          iv_load,
   output logic [W-1:0]  core_in,
   output logic          core_decrypt,
   output logic [RW-1:0] core_round,
   input  logic [W-1:0]  core_out,
   output logic          busy,
   output logic [31:0]   blk_count
);

   localparam int AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam logic [AW:0]   DEPTH_C = OUT_DEPTH[AW:0];
   localparam logic [RW-1:0] LAST    = RW'(ROUNDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, CAPTURE} state_t;

   state_t         state, state_nxt;
   logic [RW-1:0]  cnt;
   logic [W-1:0]   chain;
   logic [W-1:0]   data_lat;
   logic [W-1:0]   core_in_r;
   logic           dec_r, cbc_r;
   logic [W-1:0]   mem [OUT_DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [AW:0]    count;
   logic           in_hs, out_hs, wr_en;
   logic [W-1:0]   result;

   // A block in flight does not hold a FIFO slot, so checking for one free
   // slot at acceptance is enough to keep CAPTURE from overrunning.
   // iv_load takes priority over a same-cycle input.
   assign s_axis_tready = !rst && (state == IDLE) && !iv_load && (count < DEPTH_C);
   assign in_hs         = s_axis_tvalid && s_axis_tready;
   assign out_hs        = m_axis_tvalid && m_axis_tready;
   assign wr_en         = (state == CAPTURE);

   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = mem[rd_ptr];

   assign core_in       = core_in_r;
   assign core_decrypt  = dec_r;
   assign core_round    = cnt;
   assign busy          = (state != IDLE);

   // CBC decrypt removes the previous ciphertext after the core.
   assign result = (cbc_r && dec_r) ? (core_out ^ chain) : core_out;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_hs) state_nxt = RUN;
         RUN:     if (cnt == LAST) state_nxt = CAPTURE;
         CAPTURE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         chain     <= '0;
         core_in_r <= '0;
         dec_r     <= 1'b0;
         cbc_r     <= 1'b0;
         blk_count <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state <= state_nxt;

         // Counter returns to 0 after the last round so core_round idles at 0.
         if ((state == RUN) && (cnt != LAST))
            cnt <= cnt + RW'(1);
         else
            cnt <= '0;

         if ((state == IDLE) && iv_load)
            chain <= iv;

         if (in_hs) begin
            core_in_r <= (cbc_en && !s_axis_tuser) ? (s_axis_tdata ^ chain) : s_axis_tdata;
            dec_r     <= s_axis_tuser;
            cbc_r     <= cbc_en;
         end

         if (wr_en) begin
            blk_count <= blk_count + 32'd1;
            // Chain value is always the ciphertext block just processed.
            if (cbc_r)
               chain <= dec_r ? data_lat : core_out;
         end

         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (out_hs)
            rd_ptr <= rd_ptr + AW'(1);

         case ({wr_en, out_hs})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Datapath storage carries no reset; validity is tracked by count/state.
   always_ff @(posedge clk) begin
      if (in_hs)
         data_lat <= s_axis_tdata;
      if (wr_en)
         mem[wr_ptr] <= result;
   end

endmodule

// File: tb/tb_iter_cipher_stream.sv
module tb_iter_cipher_stream;

   localparam int W = 64;
   localparam int ROUNDS = 16;
   localparam int RW = 4;
   localparam int OUT_DEPTH = 4;
   localparam int BOUND = 400;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  s_axis_tdata;
   logic          s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          cbc_en;
   logic [W-1:0]  iv;
   logic          iv_load;
   logic [W-1:0]  core_in;
   logic          core_decrypt;
   logic [RW-1:0] core_round;
   logic [W-1:0]  core_out;
   logic          busy;
   logic [31:0]   blk_count;

   always #5 clk = ~clk;

   iter_cipher_stream #(.W(W), .ROUNDS(ROUNDS), .RW(RW), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .cbc_en(cbc_en), .iv(iv), .iv_load(iv_load),
      .core_in(core_in), .core_decrypt(core_decrypt), .core_round(core_round),
      .core_out(core_out), .busy(busy), .blk_count(blk_count)
   );

   // ---------------- DES tables ----------------
   localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,
                                62,54,46,38,30,22,14,6,64,56,48,40,32,24,16,8,
                                57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,
                                61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
   localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,
                                38,6,46,14,54,22,62,30,37,5,45,13,53,21,61,29,
                                36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,
                                34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
   localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                               16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
   localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                               2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
   localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                 63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
   localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                 41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   localparam int SH_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
   localparam int SB [512] = '{
      14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
      15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
      10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
      7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
      2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
      12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
      4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
      13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11};

   function automatic logic [63:0] des_ip(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[63-i] = x[64-IP_T[i]];
      return r;
   endfunction

   function automatic logic [63:0] des_fp(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[63-i] = x[64-FP_T[i]];
      return r;
   endfunction

   function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] e;
      logic [31:0] s;
      logic [31:0] o;
      logic [5:0]  six;
      int          idx;
      for (int i = 0; i < 48; i++) e[47-i] = r[32-E_T[i]];
      e = e ^ k;
      for (int b = 0; b < 8; b++) begin
         six = e[47-6*b -: 6];
         idx = b*64 + int'({six[5], six[0]})*16 + int'(six[4:1]);
         s[31-4*b -: 4] = 4'(SB[idx]);
      end
      for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
      return o;
   endfunction

   // ---------------- bench round cores ----------------
   logic [47:0] ks [16];
   logic [31:0] des_l, des_r;
   logic [63:0] des_out, des_in_p, toy_acc;
   logic        use_des;
   int          ki;

   assign des_in_p = des_ip(core_in);
   assign ki       = core_decrypt ? (15 - int'(core_round)) : int'(core_round);
   assign des_out  = des_fp({des_r, des_l});

   always @(posedge clk) begin
      if (core_round == '0) begin
         des_l <= des_in_p[31:0];
         des_r <= des_in_p[63:32] ^ des_f(des_in_p[31:0], ks[ki]);
      end else begin
         des_l <= des_r;
         des_r <= des_l ^ des_f(des_r, ks[ki]);
      end
   end

   always @(posedge clk)
      toy_acc <= ((core_round == '0) ? core_in : toy_acc) + 64'd1;

   assign core_out = use_des ? des_out : toy_acc;

   // ---------------- scoreboard ----------------
   logic [63:0] exp_q [$];
   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int last_out_cyc = 0;
   int n_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         last_out_cyc = cyc;
         if (exp_q.size() == 0)
            chk("unexpected_output", m_axis_tdata, 64'hx);
         else
            chk("out_data", m_axis_tdata, exp_q.pop_front());
      end
   end

   task automatic send(input logic [63:0] d, input logic dec, input logic cbc,
                       input logic [63:0] exp, input bit expect_out);
      int n;
      s_axis_tdata  = d;
      s_axis_tuser  = dec;
      cbc_en        = cbc;
      s_axis_tvalid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (s_axis_tready) break;
         n++;
         if (n > BOUND) begin
            chk("accept_timeout", 64'd0, 64'd1);
            s_axis_tvalid = 1'b0;
            return;
         end
      end
      hs_cyc = cyc;
      n_acc++;
      if (expect_out) exp_q.push_back(exp);
      @(posedge clk);
      #1 s_axis_tvalid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 || busy) begin
         @(negedge clk);
         n++;
         if (n > BOUND) begin
            chk("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_iv(input logic [63:0] v);
      iv      = v;
      iv_load = 1'b1;
      @(posedge clk);
      #1 iv_load = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [63:0] key;
      logic [55:0] cd;
      logic [27:0] c, d;
      int n;

      key = 64'h133457799BBCDFF1;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
      c = cd[55:28];
      d = cd[27:0];
      for (int r = 0; r < 16; r++) begin
         for (int s = 0; s < SH_T[r]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
         cd = {c, d};
         for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-PC2_T[i]];
      end

      rst = 1'b1; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1; cbc_en = 1'b0; iv = '0; iv_load = 1'b0; use_des = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("tready_in_reset", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_blk_count", 64'(blk_count), 64'd0);
      chk("rst_core_round", 64'(core_round), 64'd0);
      chk("rst_core_in", core_in, 64'd0);
      chk("idle_tready", 64'(s_axis_tready), 64'd1);
      @(posedge clk);
      #1;

      // toy core ECB, latency and block count
      send(64'h10, 1'b0, 1'b0, 64'h20, 1'b1);
      drain();
      chk("latency", 64'(last_out_cyc - hs_cyc), 64'(ROUNDS + 2));
      chk("blk_count_1", 64'(blk_count), 64'd1);

      // DES known-answer, both directions
      use_des = 1'b1;
      send(64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h85E813540F0AB405, 1'b1);
      send(64'h85E813540F0AB405, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b1);
      drain();
      use_des = 1'b0;

      // CBC encrypt chain
      load_iv(64'hFF);
      send(64'h01, 1'b0, 1'b1, 64'h10E, 1'b1);
      chk("cbc_core_in_1", core_in, 64'hFE);
      send(64'h02, 1'b0, 1'b1, 64'h11C, 1'b1);
      chk("cbc_core_in_2", core_in, 64'h10C);
      drain();

      // CBC decrypt chain
      load_iv(64'hFF);
      send(64'h10E, 1'b1, 1'b1, 64'h1E1, 1'b1);
      chk("cbcd_core_in", core_in, 64'h10E);
      send(64'h11C, 1'b1, 1'b1, 64'h022, 1'b1);
      drain();

      // output back-pressure
      m_axis_tready = 1'b0;
      n_acc = 0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               send(64'h100 + 64'(i), 1'b0, 1'b0, 64'h110 + 64'(i), 1'b1);
         end
         begin
            repeat (130) @(posedge clk);
            @(negedge clk);
            chk("bp_accepted", 64'(n_acc), 64'd4);
            chk("bp_tready", 64'(s_axis_tready), 64'd0);
            chk("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("bp_head_stable", m_axis_tdata, 64'h110);
            @(posedge clk);
            #1 m_axis_tready = 1'b1;
         end
      join
      drain();
      chk("bp_total_accepted", 64'(n_acc), 64'd6);

      // reset in the middle of a run
      send(64'h50, 1'b0, 1'b0, 64'h0, 1'b0);
      n = 0;
      while (core_round != 4'd7 && n < BOUND) begin
         @(negedge clk);
         n++;
      end
      chk("reached_round_7", 64'(core_round), 64'd7);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("midrst_blk_count", 64'(blk_count), 64'd0);
      repeat (30) @(posedge clk);
      #1;
      send(64'h70, 1'b0, 1'b1, 64'h80, 1'b1);
      chk("postrst_core_in", core_in, 64'h70);
      drain();
      chk("postrst_blk_count", 64'(blk_count), 64'd1);

      // iv_load has priority over a same-cycle input
      iv = 64'h0F;
      iv_load = 1'b1;
      s_axis_tdata = 64'h03; s_axis_tuser = 1'b0; cbc_en = 1'b1; s_axis_tvalid = 1'b1;
      @(negedge clk);
      chk("ivload_tready", 64'(s_axis_tready), 64'd0);
      @(posedge clk);
      #1 iv_load = 1'b0;
      chk("ivload_busy", 64'(busy), 64'd0);
      send(64'h03, 1'b0, 1'b1, 64'h1C, 1'b1);
      chk("ivload_core_in", core_in, 64'h0C);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
